// File: rtl/scoreboard_regfile_if.sv
// rtl/scoreboard_regfile_if.sv - bus bundle for the scoreboarded register file
//
// Purpose: groups the read, write, claim and status signals of
//   scoreboard_regfile so issue/execute logic connects through one port.
// Ports (signals):
//   rd_addr    NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    NUM_RD*DATA_W  packed read data, same packing
//   rd_hazard  NUM_RD         per-port operand-not-yet-valid flag
//   wr_en      2              write enables (0: ALU result, 1: load/base writeback)
//   wr_addr    2*ADDR_W       packed write addresses
//   wr_data    2*DATA_W       packed write data
//   claim_en   1              issue-stage claim of claim_addr
//   claim_addr ADDR_W         register being claimed
//   claim_ok   1              claim_addr currently not busy
//   flush      1              clear all pending marks
//   busy_vec   NREGS          registered busy bit per register
//   sb_err     1              sticky protocol error
// Modports: master drives requests (pipeline side), slave is the register file.

interface scoreboard_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 3
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_hazard;
  logic [1:0]               wr_en;
  logic [2*ADDR_W-1:0]      wr_addr;
  logic [2*DATA_W-1:0]      wr_data;
  logic                     claim_en;
  logic [ADDR_W-1:0]        claim_addr;
  logic                     claim_ok;
  logic                     flush;
  logic [NREGS-1:0]         busy_vec;
  logic                     sb_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr, flush,
    input  rd_data, rd_hazard, claim_ok, busy_vec, sb_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr, flush,
    output rd_data, rd_hazard, claim_ok, busy_vec, sb_err
  );
endinterface

// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - multi-read, dual-write register file with busy scoreboard
//
// Purpose: NREGS x DATA_W register array with NUM_RD combinational read ports
//   (write-through bypass), two write ports, and a per-register busy bit set by
//   issue-stage claims and cleared by writeback or flush.
// Ports:
//   clk  in  clock, all state on rising edge
//   rst  in  asynchronous active-high reset
//   bus  scoreboard_regfile_if.slave (see interface file for signal list)

module scoreboard_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 3
) (
  input  logic                clk,
  input  logic                rst,
  scoreboard_regfile_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic              r_sb_err;

  logic [ADDR_W-1:0] w_wa [2];
  logic [DATA_W-1:0] w_wd [2];
  logic [NREGS-1:0]  w_busy_nxt;
  logic              w_claim;
  logic              w_err;

  assign w_wa[0] = bus.wr_addr[0 +: ADDR_W];
  assign w_wa[1] = bus.wr_addr[ADDR_W +: ADDR_W];
  assign w_wd[0] = bus.wr_data[0 +: DATA_W];
  assign w_wd[1] = bus.wr_data[DATA_W +: DATA_W];

  // A claim only takes effect when no flush is in progress.
  assign w_claim = bus.claim_en & ~bus.flush;

  // Writeback clears first so a same-cycle claim of the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int k = 0; k < 2; k++) begin
      if (bus.wr_en[k]) w_busy_nxt[w_wa[k]] = 1'b0;
    end
    if (bus.flush) begin
      w_busy_nxt = '0;
    end else if (bus.claim_en) begin
      w_busy_nxt[bus.claim_addr] = 1'b1;
    end
  end

  // Protocol errors: claiming a busy register, or writing back a register
  // nobody claimed (a same-cycle claim counts as the claim).
  always_comb begin
    w_err = w_claim & r_busy[bus.claim_addr];
    for (int k = 0; k < 2; k++) begin
      if (bus.wr_en[k] && !r_busy[w_wa[k]] &&
          !(w_claim && (bus.claim_addr == w_wa[k]))) begin
        w_err = 1'b1;
      end
    end
  end

  // Read ports: port 1 bypass beats port 0, and bypass is suppressed in reset
  // so reads return the (cleared) array contents.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit0;
    logic              w_hit1;

    assign w_ra   = bus.rd_addr[i*ADDR_W +: ADDR_W];
    assign w_hit0 = ~rst & bus.wr_en[0] & (w_wa[0] == w_ra);
    assign w_hit1 = ~rst & bus.wr_en[1] & (w_wa[1] == w_ra);

    assign bus.rd_data[i*DATA_W +: DATA_W] = w_hit1 ? w_wd[1] :
                                             w_hit0 ? w_wd[0] : r_mem[w_ra];
    assign bus.rd_hazard[i] = ~rst & r_busy[w_ra] & ~(w_hit0 | w_hit1);
  end

  assign bus.claim_ok = ~r_busy[bus.claim_addr];
  assign bus.busy_vec = r_busy;
  assign bus.sb_err   = r_sb_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NREGS; j++) r_mem[j] <= '0;
      r_busy   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      // Port 1 is written last so it wins an address collision.
      if (bus.wr_en[0]) r_mem[w_wa[0]] <= w_wd[0];
      if (bus.wr_en[1]) r_mem[w_wa[1]] <= w_wd[1];
      r_busy <= w_busy_nxt;
      if (w_err) r_sb_err <= 1'b1;
    end
  end
endmodule
